// File: rtl/floor_gen.sv
// Scrolling floor generator: eight 40 px floors scroll down in bursts when the slime climbs high, recycling at the bottom.
// Latency: one core clock from a qualifying clk_vga tick to every output; all outputs come straight from flops.
// Backpressure: none; clk_vga gates all movement, and only the LFSR free-runs (it halts in OVER).
//
// Ports:
//   clk, rst (async, active-high), clk_vga (tick enable), slime_y (slime top row)
//   floor_pos_x0..7 / floor_pos_y0..7 : floor left x / top row
//   enable (bit i = floor i solid), scrolling, game_over, score (recycled floor count)
module floor_gen #(
    parameter logic [9:0] SCROLL_LINE = 10'd200,
    parameter logic [8:0] SCROLL_LEN  = 9'd120,
    parameter logic [9:0] LFSR_SEED   = 10'h2A5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_vga,
    input  logic [9:0]  slime_y,
    output logic [9:0]  floor_pos_x0,
    output logic [9:0]  floor_pos_x1,
    output logic [9:0]  floor_pos_x2,
    output logic [9:0]  floor_pos_x3,
    output logic [9:0]  floor_pos_x4,
    output logic [9:0]  floor_pos_x5,
    output logic [9:0]  floor_pos_x6,
    output logic [9:0]  floor_pos_x7,
    output logic [9:0]  floor_pos_y0,
    output logic [9:0]  floor_pos_y1,
    output logic [9:0]  floor_pos_y2,
    output logic [9:0]  floor_pos_y3,
    output logic [9:0]  floor_pos_y4,
    output logic [9:0]  floor_pos_y5,
    output logic [9:0]  floor_pos_y6,
    output logic [9:0]  floor_pos_y7,
    output logic [7:0]  enable,
    output logic        scrolling,
    output logic        game_over,
    output logic [15:0] score
);

    typedef enum logic [1:0] {IDLE, SCROLL, OVER} state_t;

    // Element 0 is the rightmost entry.
    localparam logic [7:0][9:0] X_INIT = {10'd140, 10'd360, 10'd40,  10'd560,
                                          10'd200, 10'd480, 10'd80,  10'd300};
    localparam logic [7:0][9:0] Y_INIT = {10'd50,  10'd100, 10'd150, 10'd200,
                                          10'd250, 10'd300, 10'd350, 10'd400};
    localparam logic [9:0]      Y_LAST = 10'd479;

    state_t          r_state;
    logic [8:0]      r_cnt;
    logic [9:0]      r_lfsr;
    logic [7:0][9:0] r_fx;
    logic [7:0][9:0] r_fy;
    logic [7:0]      r_en;
    logic            r_last_gap;
    logic [15:0]     r_score;
    logic            r_scrolling;
    logic            r_game_over;

    logic [7:0][9:0] w_fx_nxt;
    logic [7:0][9:0] w_fy_nxt;
    logic [7:0]      w_en_nxt;
    logic            w_gap_nxt;
    logic [3:0]      w_nrec;
    logic [19:0]     w_rot2;
    logic [9:0]      w_r;
    logic [16:0]     w_sum;
    logic [15:0]     w_score_nxt;

    // Next floor set for one scroll step. Floors are visited in index order,
    // so within a tick a lower-index recycle counts as "earlier" for the
    // no-two-gaps rule and the highest-index recycle owns the final flag.
    always_comb begin
        w_fx_nxt  = r_fx;
        w_fy_nxt  = r_fy;
        w_en_nxt  = r_en;
        w_gap_nxt = r_last_gap;
        w_nrec    = '0;
        w_rot2    = '0;
        w_r       = '0;
        for (int i = 0; i < 8; i++) begin
            if (r_fy[i] == Y_LAST) begin
                // Rotate-left by i: top half of the doubled word shifted by i.
                w_rot2        = {r_lfsr, r_lfsr} << i;
                w_r           = w_rot2[19:10];
                w_fy_nxt[i]   = '0;
                w_fx_nxt[i]   = (w_r < 10'd580) ? w_r : (w_r - 10'd512);
                w_en_nxt[i]   = w_gap_nxt | ~(w_r[9] & w_r[3]);
                w_gap_nxt     = ~w_en_nxt[i];
                w_nrec        = w_nrec + 4'd1;
            end else begin
                w_fy_nxt[i]   = r_fy[i] + 10'd1;
            end
        end
        w_sum       = {1'b0, r_score} + {13'd0, w_nrec};
        w_score_nxt = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_lfsr      <= LFSR_SEED;
            r_fx        <= X_INIT;
            r_fy        <= Y_INIT;
            r_en        <= 8'hFF;
            r_last_gap  <= 1'b0;
            r_score     <= '0;
            r_scrolling <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            // x^10 + x^7 + 1, free-running on clk until the game ends.
            if (r_state != OVER) begin
                r_lfsr <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
            end
            if (clk_vga) begin
                case (r_state)
                    IDLE: begin
                        if (slime_y == Y_LAST) begin
                            r_state     <= OVER;
                            r_game_over <= 1'b1;
                        end else if (slime_y < SCROLL_LINE) begin
                            r_state     <= SCROLL;
                            r_cnt       <= SCROLL_LEN;
                            r_scrolling <= 1'b1;
                        end
                    end
                    SCROLL: begin
                        // The fatal tick freezes the field as it stands; no step is taken.
                        if (slime_y == Y_LAST) begin
                            r_state     <= OVER;
                            r_game_over <= 1'b1;
                            r_scrolling <= 1'b0;
                        end else begin
                            r_fx       <= w_fx_nxt;
                            r_fy       <= w_fy_nxt;
                            r_en       <= w_en_nxt;
                            r_last_gap <= w_gap_nxt;
                            r_score    <= w_score_nxt;
                            r_cnt      <= (r_cnt == 9'd0) ? 9'd0 : (r_cnt - 9'd1);
                            if (r_cnt <= 9'd1) begin
                                r_state     <= IDLE;
                                r_scrolling <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign floor_pos_x0 = r_fx[0];
    assign floor_pos_x1 = r_fx[1];
    assign floor_pos_x2 = r_fx[2];
    assign floor_pos_x3 = r_fx[3];
    assign floor_pos_x4 = r_fx[4];
    assign floor_pos_x5 = r_fx[5];
    assign floor_pos_x6 = r_fx[6];
    assign floor_pos_x7 = r_fx[7];
    assign floor_pos_y0 = r_fy[0];
    assign floor_pos_y1 = r_fy[1];
    assign floor_pos_y2 = r_fy[2];
    assign floor_pos_y3 = r_fy[3];
    assign floor_pos_y4 = r_fy[4];
    assign floor_pos_y5 = r_fy[5];
    assign floor_pos_y6 = r_fy[6];
    assign floor_pos_y7 = r_fy[7];
    assign enable       = r_en;
    assign scrolling    = r_scrolling;
    assign game_over    = r_game_over;
    assign score        = r_score;

endmodule

// File: tb/tb_floor_gen.sv
// Self-checking bench for floor_gen: constant vectors, directed corner sequences and a
// randomized run against a behavioural model of the floor field.
// Inputs are driven 1 time unit after the rising edge; outputs are compared there too.
module tb_floor_gen;

    logic        clk;
    logic        rst;
    logic        clk_vga;
    logic [9:0]  slime_y;
    logic [9:0]  floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3;
    logic [9:0]  floor_pos_x4, floor_pos_x5, floor_pos_x6, floor_pos_x7;
    logic [9:0]  floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3;
    logic [9:0]  floor_pos_y4, floor_pos_y5, floor_pos_y6, floor_pos_y7;
    logic [7:0]  enable;
    logic        scrolling;
    logic        game_over;
    logic [15:0] score;

    floor_gen dut (
        .clk(clk), .rst(rst), .clk_vga(clk_vga), .slime_y(slime_y),
        .floor_pos_x0(floor_pos_x0), .floor_pos_x1(floor_pos_x1),
        .floor_pos_x2(floor_pos_x2), .floor_pos_x3(floor_pos_x3),
        .floor_pos_x4(floor_pos_x4), .floor_pos_x5(floor_pos_x5),
        .floor_pos_x6(floor_pos_x6), .floor_pos_x7(floor_pos_x7),
        .floor_pos_y0(floor_pos_y0), .floor_pos_y1(floor_pos_y1),
        .floor_pos_y2(floor_pos_y2), .floor_pos_y3(floor_pos_y3),
        .floor_pos_y4(floor_pos_y4), .floor_pos_y5(floor_pos_y5),
        .floor_pos_y6(floor_pos_y6), .floor_pos_y7(floor_pos_y7),
        .enable(enable), .scrolling(scrolling), .game_over(game_over), .score(score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] ox [8];
    logic [9:0] oy [8];
    assign ox[0] = floor_pos_x0; assign ox[1] = floor_pos_x1;
    assign ox[2] = floor_pos_x2; assign ox[3] = floor_pos_x3;
    assign ox[4] = floor_pos_x4; assign ox[5] = floor_pos_x5;
    assign ox[6] = floor_pos_x6; assign ox[7] = floor_pos_x7;
    assign oy[0] = floor_pos_y0; assign oy[1] = floor_pos_y1;
    assign oy[2] = floor_pos_y2; assign oy[3] = floor_pos_y3;
    assign oy[4] = floor_pos_y4; assign oy[5] = floor_pos_y5;
    assign oy[6] = floor_pos_y6; assign oy[7] = floor_pos_y7;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- behavioural model ----------------
    // m_mode: 0 waiting, 1 scrolling, 2 game over
    int m_mode, m_steps_left, m_lfsr, m_score, m_last_gap;
    int m_fx [8];
    int m_fy [8];
    int m_en [8];
    int rx [8] = '{300, 80, 480, 200, 560, 40, 360, 140};

    function automatic void model_reset();
        m_mode = 0; m_steps_left = 0; m_lfsr = 'h2A5; m_score = 0; m_last_gap = 0;
        for (int i = 0; i < 8; i++) begin
            m_fx[i] = rx[i];
            m_fy[i] = 400 - 50 * i;
            m_en[i] = 1;
        end
    endfunction

    function automatic void model_step(input bit v, input int sy);
        int old, r, n, gap;
        old = m_lfsr;
        if (m_mode != 2)
            m_lfsr = ((m_lfsr * 2) % 1024) + (((m_lfsr / 512) + (m_lfsr / 64)) % 2);
        if (!v || m_mode == 2) return;
        if (sy == 479) begin m_mode = 2; return; end
        if (m_mode == 0) begin
            if (sy < 200) begin m_mode = 1; m_steps_left = 120; end
            return;
        end
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_fy[i] == 479) begin
                r = ((old * (1 << i)) + (old / (1 << (10 - i)))) % 1024;
                m_fx[i] = (r < 580) ? r : r - 512;
                m_fy[i] = 0;
                gap = ((r / 512) % 2 == 1) && ((r / 8) % 2 == 1);
                if (m_last_gap != 0) gap = 0;
                m_en[i] = gap ? 0 : 1;
                m_last_gap = gap;
                n++;
            end else begin
                m_fy[i] = m_fy[i] + 1;
            end
        end
        m_score = (m_score + n > 65535) ? 65535 : m_score + n;
        m_steps_left--;
        if (m_steps_left == 0) m_mode = 0;
    endfunction

    function automatic int model_en_vec();
        int ev = 0;
        for (int i = 0; i < 8; i++) ev += m_en[i] * (1 << i);
        return ev;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s x%0d", tag, i), int'(ox[i]), m_fx[i]);
            chk($sformatf("%s y%0d", tag, i), int'(oy[i]), m_fy[i]);
        end
        chk({tag, " enable"}, int'(enable), model_en_vec());
        chk({tag, " scrolling"}, int'(scrolling), (m_mode == 1) ? 1 : 0);
        chk({tag, " game_over"}, int'(game_over), (m_mode == 2) ? 1 : 0);
        chk({tag, " score"}, int'(score), m_score);
    endtask

    task automatic check_reset_consts(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s rst x%0d", tag, i), int'(ox[i]), rx[i]);
            chk($sformatf("%s rst y%0d", tag, i), int'(oy[i]), 400 - 50 * i);
        end
        chk({tag, " rst enable"}, int'(enable), 255);
        chk({tag, " rst score"}, int'(score), 0);
        chk({tag, " rst scrolling"}, int'(scrolling), 0);
        chk({tag, " rst game_over"}, int'(game_over), 0);
    endtask

    task automatic cyc(input bit v, input int sy);
        clk_vga = v;
        slime_y = 10'(sy);
        @(posedge clk);
        if (!rst) model_step(v, sy);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clk_vga = 1'b0; slime_y = 10'd379;
        #1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic force_lfsr_3ff();
        force dut.r_lfsr = 10'h3FF;
        #1;
        release dut.r_lfsr;
        m_lfsr = 'h3FF;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit vga;
        int sy;
        bit exp_scr;
        bit exp_ovr;
        int exp_y0;
    } vec_t;
    vec_t tbl [9];

    logic [7:0][9:0] fv;
    int snap_x [8];
    int snap_y [8];
    int snap_en, snap_sc;
    bit rv;
    int rsy, p;

    initial begin
        tbl[0] = '{1'b1, 379, 1'b0, 1'b0, 400};
        tbl[1] = '{1'b0, 150, 1'b0, 1'b0, 400};   // no tick: ignored
        tbl[2] = '{1'b1, 200, 1'b0, 1'b0, 400};   // exactly on the line: no scroll
        tbl[3] = '{1'b1, 199, 1'b1, 1'b0, 400};   // start burst, no step yet
        tbl[4] = '{1'b1, 100, 1'b1, 1'b0, 401};
        tbl[5] = '{1'b0, 479, 1'b1, 1'b0, 401};   // 479 without tick is harmless
        tbl[6] = '{1'b1, 300, 1'b1, 1'b0, 402};
        tbl[7] = '{1'b1, 479, 1'b0, 1'b1, 402};
        tbl[8] = '{1'b1, 100, 1'b0, 1'b1, 402};

        rst = 1'b1; clk_vga = 1'b0; slime_y = 10'd379;

        // Reset, then idle ticks leave everything at reset values.
        do_reset();
        check_reset_consts("reset");
        for (int k = 0; k < 10; k++) cyc(1'b1, 379);
        check_reset_consts("idle10");
        check_all("idle10");

        // Table vectors.
        for (int k = 0; k < 9; k++) begin
            cyc(tbl[k].vga, tbl[k].sy);
            chk($sformatf("tbl%0d scrolling", k), int'(scrolling), int'(tbl[k].exp_scr));
            chk($sformatf("tbl%0d game_over", k), int'(game_over), int'(tbl[k].exp_ovr));
            chk($sformatf("tbl%0d y0", k), int'(floor_pos_y0), tbl[k].exp_y0);
            check_all($sformatf("tbl%0d", k));
        end

        // Full burst: floor0 recycles at step 80 and ends at 40.
        do_reset();
        cyc(1'b1, 150);
        chk("burst start scrolling", int'(scrolling), 1);
        for (int k = 0; k < 119; k++) begin
            cyc(1'b1, (k % 7 == 0) ? 50 : 379);   // low slime mid-burst must not reload
            check_all("burst");
        end
        chk("burst step119 scrolling", int'(scrolling), 1);
        cyc(1'b1, 379);
        chk("burst end scrolling", int'(scrolling), 0);
        chk("burst end y0", int'(floor_pos_y0), 40);
        chk("burst end y1", int'(floor_pos_y1), 470);
        chk("burst end score", int'(score), 1);
        chk("burst x0 range", (floor_pos_x0 < 10'd580) ? 1 : 0, 1);
        check_all("burst end");

        // Mid-scroll async reset.
        cyc(1'b1, 150);
        cyc(1'b1, 379);
        chk("pre-arst scrolling", int'(scrolling), 1);
        rst = 1'b1;
        #1;
        check_reset_consts("arst scroll");
        do_reset();

        // Two consecutive recycles that both compute a gap.
        cyc(1'b1, 150);
        for (int k = 0; k < 79; k++) cyc(1'b1, 379);
        chk("gap1 y0 before", int'(floor_pos_y0), 479);
        force_lfsr_3ff();
        cyc(1'b1, 379);
        chk("gap1 en0", int'(enable[0]), 0);
        chk("gap1 y0", int'(floor_pos_y0), 0);
        chk("gap1 x0", int'(floor_pos_x0), 511);
        chk("gap1 score", int'(score), 1);
        check_all("gap1");
        for (int k = 0; k < 40; k++) cyc(1'b1, 379);
        chk("gap idle scrolling", int'(scrolling), 0);
        cyc(1'b1, 150);
        for (int k = 0; k < 9; k++) cyc(1'b1, 379);
        chk("gap2 y1 before", int'(floor_pos_y1), 479);
        force_lfsr_3ff();
        cyc(1'b1, 379);
        chk("gap2 en1 forced", int'(enable[1]), 1);
        chk("gap2 en0 kept", int'(enable[0]), 0);
        chk("gap2 y1", int'(floor_pos_y1), 0);
        chk("gap2 x1", int'(floor_pos_x1), 511);
        check_all("gap2");

        // Simultaneous recycles with score near saturation.
        do_reset();
        cyc(1'b1, 150);
        for (int i = 0; i < 8; i++) begin
            fv[i] = (i < 2) ? 10'd479 : 10'(100 + 10 * i);
            m_fy[i] = int'(fv[i]);
        end
        force dut.r_fy = fv;
        force dut.r_score = 16'hFFFE;
        force dut.r_lfsr = 10'h3FF;
        #1;
        release dut.r_fy;
        release dut.r_score;
        release dut.r_lfsr;
        m_score = 'hFFFE;
        m_lfsr = 'h3FF;
        cyc(1'b1, 379);
        chk("sat score", int'(score), 'hFFFF);
        chk("sat y0", int'(floor_pos_y0), 0);
        chk("sat y1", int'(floor_pos_y1), 0);
        chk("sat en0 gap", int'(enable[0]), 0);
        chk("sat en1 forced", int'(enable[1]), 1);
        check_all("sat");
        for (int i = 0; i < 8; i++) begin
            fv[i] = (i == 2) ? 10'd479 : 10'(m_fy[i]);
            m_fy[i] = int'(fv[i]);
        end
        force dut.r_fy = fv;
        #1;
        release dut.r_fy;
        cyc(1'b1, 379);
        chk("sat hold score", int'(score), 'hFFFF);
        chk("sat hold y2", int'(floor_pos_y2), 0);
        check_all("sat hold");

        // Game over from SCROLL freezes everything until reset.
        do_reset();
        cyc(1'b1, 150);
        for (int k = 0; k < 5; k++) cyc(1'b1, 379);
        cyc(1'b1, 479);
        chk("over game_over", int'(game_over), 1);
        chk("over scrolling", int'(scrolling), 0);
        chk("over y0", int'(floor_pos_y0), 405);
        for (int i = 0; i < 8; i++) begin
            snap_x[i] = int'(ox[i]);
            snap_y[i] = int'(oy[i]);
        end
        snap_en = int'(enable);
        snap_sc = int'(score);
        for (int k = 0; k < 50; k++) cyc(1'($urandom_range(0, 1)), (k % 3 == 0) ? 100 : 479);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("frozen x%0d", i), int'(ox[i]), snap_x[i]);
            chk($sformatf("frozen y%0d", i), int'(oy[i]), snap_y[i]);
        end
        chk("frozen enable", int'(enable), snap_en);
        chk("frozen score", int'(score), snap_sc);
        chk("frozen game_over", int'(game_over), 1);
        check_all("frozen");
        rst = 1'b1;
        #1;
        check_reset_consts("arst over");
        do_reset();

        // Randomized run against the model, with periodic async resets.
        for (int k = 0; k < 6000; k++) begin
            rv = ($urandom_range(0, 1) == 1);
            p = int'($urandom_range(0, 99));
            rsy = (p < 6) ? int'($urandom_range(0, 199)) : int'($urandom_range(200, 478));
            if (k == 5990) begin rv = 1'b1; rsy = 479; end
            cyc(rv, rsy);
            check_all("rnd");
            if (k % 2000 == 1999) begin
                rst = 1'b1;
                #1;
                check_reset_consts("rnd arst");
                do_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/floor_gen.md
FLOOR_GEN -- requirements
Module: floor_gen

Interface
REQ-001 Parameter SCROLL_LINE, default 10'd200, slime y below which a scroll burst starts.
REQ-002 Parameter SCROLL_LEN, default 9'd120, scroll steps per burst.
REQ-003 Parameter LFSR_SEED, default 10'h2A5, LFSR reset value; SHALL be nonzero.
REQ-004 clk  input  1  system clock; only clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 clk_vga  input  1  one-cycle tick enable; all movement advances only on clk cycles with clk_vga=1.
REQ-007 slime_y  input  10  current slime top-row y.
REQ-008 floor_pos_x0..floor_pos_x7  output  10 each  floor left x; floor width is 40 px.
REQ-009 floor_pos_y0..floor_pos_y7  output  10 each  floor top row.
REQ-010 enable  output  8  bit i=1 means floor i is solid.
REQ-011 scrolling  output  1  high in SCROLL state.
REQ-012 game_over  output  1  high in OVER state.
REQ-013 score  output  16  count of recycled floors.

Function
REQ-014 All outputs SHALL be registered; changes SHALL appear the clk edge after the qualifying tick (1-cycle latency).
REQ-015 FSM states SHALL be IDLE, SCROLL, OVER.
REQ-016 Any state except OVER -> OVER on a tick with slime_y==479; this has priority over every other transition.
REQ-017 IDLE -> SCROLL on a tick with slime_y < SCROLL_LINE; the step counter loads SCROLL_LEN.
REQ-018 SCROLL: each tick, every floor y increments by 1 and the counter decrements; after the tick where the counter reaches 0, state returns to IDLE.
REQ-019 slime_y < SCROLL_LINE while in SCROLL SHALL NOT reload the counter.
REQ-020 OVER: positions, enable and score SHALL freeze; OVER exits only via rst.
REQ-021 Recycle: a floor with y==479 at a scroll step SHALL take y=0 (not 480) and a new x.
REQ-022 New x for floor i: r = current LFSR rotated left by i; x = r if r < 580, else r - 512.
REQ-023 The 10-bit LFSR (taps x^10+x^7+1) SHALL advance every clk cycle, independent of clk_vga and state, except in OVER.
REQ-024 On recycle, enable[i] = ~(r[9] & r[3]).
REQ-025 If the most recently recycled floor was disabled, enable[i] SHALL be forced to 1 (no two consecutive gaps).
REQ-026 Simultaneous recycles SHALL each use their own rotation; the "last recycled" flag SHALL take the highest-index floor.
REQ-027 score SHALL increment by the number of floors recycled in that tick and saturate at 16'hFFFF.
REQ-028 clk_vga=0 SHALL hold all state except the LFSR.

Reset
REQ-029 On rst, SHALL set state=IDLE, counter=0, LFSR=LFSR_SEED, score=0, enable=8'hFF, last-gap flag=0, scrolling=0, game_over=0.
REQ-030 On rst, floor_pos_y_i = 400 - 50*i (400, 350, 300, 250, 200, 150, 100, 50).
REQ-031 On rst, floor_pos_x0..7 = 300, 80, 480, 200, 560, 40, 360, 140.
REQ-032 Reset asserted mid-SCROLL or in OVER SHALL restore all REQ-029..031 values immediately, without waiting for a clk edge.

Verification
REQ-033 Reset, then 10 ticks with slime_y=379: state IDLE, all floors at reset values, score=0.
REQ-034 Tick with slime_y=150: scrolling=1 next cycle; after 120 ticks floor_pos_y0=520?? not allowed -- floor0 y=400+120 recycles at step 80 -> y0=40, score=1, scrolling=0 after tick 120.
REQ-035 Force floor y=479, scroll one tick: y=0, x<580, score+1; enable follows REQ-024/025.
REQ-036 Preload the LFSR so two consecutive recycles both compute a gap: the second recycle's enable bit SHALL be 1.
REQ-037 In SCROLL, drive slime_y=479 on a tick: game_over=1 next cycle; 50 further ticks leave outputs unchanged; rst clears game_over asynchronously.
REQ-038 Preload score=16'hFFFE and trigger 2 simultaneous recycles: score=16'hFFFF.
